digit_scan_driver: RTL and testbench
====================================

Name: digit_scan_driver

Overview:
Upstream feeder for the per-digit seven-segment decoder on the vending machine board. It takes a binary credit/price value, converts it to packed BCD with a sequential shift-add-3 engine, and time-multiplexes the digits. Each cycle it presents one 4-bit digit code to the decoder and drives the matching active-low anode. Code 4'hF is the blank code; the downstream decoder maps any value above 9 to all segments off.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (RTL and bench fixed at 4)
VALUE_W, 14, width of binary input value (max encodable 16383)
REFRESH_DIV, 50000, clk cycles each digit stays lit (>=2)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
value  input  VALUE_W  binary value to display, sampled on load
load  input  1  one-cycle request to convert and display value
blank_lz  input  1  1 = blank leading zeros (digit 0 never blanked)
digit_code  output  4  BCD digit (0-9) or 4'hF blank, to decoder input
anode  output  NUM_DIGITS  active-low one-hot digit enable
busy  output  1  conversion in progress
done  output  1  one-cycle pulse when new digits become visible
overflow  output  1  last loaded value exceeded 9999

Behaviour:
- Reset (async assert, sync release):
  - anode=4'b1110, digit_code=4'h0, busy=0, done=0, overflow=0.
  - Displayed BCD register = 0000; scan index=0; refresh counter=0.
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: load=1 latches value into the shift register and clears the BCD work register. Next state SHIFT; busy=1 from the following cycle.
  - SHIFT: exactly VALUE_W cycles. Each cycle, add 3 to every work nibble >=5, then shift left 1 with the value MSB entering. Bit counter counts VALUE_W-1 down to 0.
  - COMMIT: one cycle. Copy the work register to the display register; done=1 this cycle only; busy=0 in this cycle; return to IDLE.
  - Latency: load at cycle N -> done at cycle N+VALUE_W+2. New digits appear on digit_code from cycle N+VALUE_W+3.
- Overflow:
  - value >9999 at load -> display register saturates to 9999 at COMMIT and overflow=1.
  - overflow is updated at every COMMIT and holds between loads.
- load while busy (SHIFT or COMMIT): ignored, no queueing. Bench checks the display reflects the first value.
- Display register changes only in COMMIT. No partial or mid-conversion digits ever reach digit_code.
- Scan:
  - Refresh counter runs 0..REFRESH_DIV-1 continuously, independent of the FSM.
  - On the terminal count the counter wraps to 0 and the scan index advances 0->1->2->3->0.
  - digit_code and anode are registered together and update in the same cycle, so they never mismatch.
  - anode[i]=0 exactly when index=i; never more than one low.
- Leading-zero blanking (blank_lz=1): digit i>0 outputs 4'hF when it and all higher digits are 0. Digit 0 always shows its value. The decision uses the committed display register and is evaluated combinationally on blank_lz at output register load.
- Reset mid-conversion: aborts immediately to IDLE with all reset values. The next load starts a clean conversion.

Test Plan:
- REFRESH_DIV=4. Reset, then release -> anode cycles 1110,1101,1011,0111 with 4 clk per digit; digit_code=0 throughout; busy=0.
- load with value=1234, blank_lz=0 -> busy high 14 cycles, done pulse at load+16. Scan then shows index0=4, 1=3, 2=2, 3=1; overflow=0.
- value=7, blank_lz=1 -> digit0=7, digits1-3=4'hF. Then blank_lz=0 -> digits1-3=0.
- value=12000 -> all digits 9, overflow=1. Then load 0 -> overflow=0, all digits 0 (blank_lz=0).
- load 5678, then load 1111 during SHIFT -> second ignored; display 5678; exactly one done pulse.
- load 4321, assert rst_n=0 at load+5 -> immediate reset values; no done; display stays 0 after release.

Source files
------------

// File: rtl/digit_scan_driver.sv
// digit_scan_driver: converts a binary value to packed BCD with a sequential
// shift-add-3 engine and time-multiplexes the digits onto one shared digit
// code bus with matching active-low anodes.
// Latency: load sampled at cycle N -> done at N+VALUE_W+2, digits shown from N+VALUE_W+3.
// Backpressure: loads arriving while a conversion is in flight are dropped.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   value, load         binary value and one-cycle convert request
//   blank_lz            blank leading zeros (digit 0 is never blanked)
//   digit_code, anode   registered digit code (0-9 or 4'hF blank) and one-hot-low anode
//   busy, done          conversion in progress, one-cycle pulse when new digits are committed
//   overflow            last loaded value did not fit in NUM_DIGITS decimal digits
module digit_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int VALUE_W     = 14,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [3:0]            digit_code,
  output logic [NUM_DIGITS-1:0] anode,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BIT_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;

  localparam logic [VALUE_W-1:0]    MAX_VAL   = VALUE_W'(10**NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BIT_W-1:0]      BIT_LAST  = BIT_W'(VALUE_W - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_RST = ~NUM_DIGITS'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [VALUE_W-1:0]      shift_q, shift_d;
  logic [BCD_W-1:0]        work_q, work_d, work_adj;
  logic [BCD_W-1:0]        disp_q, disp_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic                    ovf_pend_q, ovf_pend_d;
  logic                    overflow_q, overflow_d;
  logic                    done_q, done_d;

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [3:0]              code_q, code_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [NUM_DIGITS-1:0]   lead_zero;
  logic                    higher_zero;

  // Add-3 correction: any nibble >= 5 would exceed 9 after the doubling shift.
  always_comb begin
    work_adj = work_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) begin
        work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    work_d     = work_q;
    bit_d      = bit_q;
    ovf_pend_d = ovf_pend_q;
    disp_d     = disp_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          shift_d    = value;
          work_d     = '0;
          bit_d      = BIT_LAST;
          // Out-of-range is decided up front; the top digit of the work
          // register is allowed to wrap since the result is replaced anyway.
          ovf_pend_d = (value > MAX_VAL);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        work_d  = (work_adj << 1) | BCD_W'(shift_q[VALUE_W-1]);
        shift_d = shift_q << 1;
        if (bit_q == '0) begin
          state_d = COMMIT;
        end else begin
          bit_d = bit_q - 1'b1;
        end
      end
      COMMIT: begin
        disp_d     = ovf_pend_q ? {NUM_DIGITS{4'h9}} : work_q;
        overflow_d = ovf_pend_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan: free-running refresh divider, index advance and digit selection.
  // The output register is loaded from the next index so anode always
  // matches idx_q and digit_code/anode change on the same edge.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // lead_zero[i]: digit i and every digit above it are zero.
    higher_zero = 1'b1;
    lead_zero   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      higher_zero  = higher_zero & (disp_q[4*i +: 4] == 4'h0);
      lead_zero[i] = higher_zero;
    end

    code_d  = 4'h0;
    anode_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        code_d     = (blank_lz && (i != 0) && lead_zero[i]) ? 4'hF : disp_q[4*i +: 4];
        anode_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      work_q     <= '0;
      bit_q      <= '0;
      ovf_pend_q <= 1'b0;
      disp_q     <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      code_q     <= 4'h0;
      anode_q    <= ANODE_RST;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      work_q     <= work_d;
      bit_q      <= bit_d;
      ovf_pend_q <= ovf_pend_d;
      disp_q     <= disp_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      code_q     <= code_d;
      anode_q    <= anode_d;
    end
  end

  assign digit_code = code_q;
  assign anode      = anode_q;
  assign busy       = (state_q == SHIFT);
  assign done       = done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_digit_scan_driver.sv
// tb_digit_scan_driver: table-driven vectors, hand-written corner sequences
// and randomized loads, all checked against a cycle-level reference model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_digit_scan_driver;

  logic        clk;
  logic        rst_n;
  logic [13:0] value;
  logic        load;
  logic        blank_lz;
  logic [3:0]  digit_code;
  logic [3:0]  anode;
  logic        busy;
  logic        done;
  logic        overflow;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  digit_scan_driver #(
    .NUM_DIGITS  (4),
    .VALUE_W     (14),
    .REFRESH_DIV (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .load       (load),
    .blank_lz   (blank_lz),
    .digit_code (digit_code),
    .anode      (anode),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Decimal digit i of v, or 15 for a blanked leading zero.
  function automatic int digit_of(input int v, input int i, input bit blz);
    int p;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    if (blz && i > 0 && v < p) return 15;
    return (v / p) % 10;
  endfunction

  // Reference model: timeline of edges since reset; a conversion accepted at
  // edge a commits at edge a+15, and loads in between are dropped.
  int       m_e, m_acc, m_val, m_disp, m_idx;
  bit       m_infl, m_ovf, m_busy, m_done;
  int       m_code;
  logic [3:0] m_anode;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_e = 0; m_acc = 0; m_val = 0; m_disp = 0; m_infl = 0; m_ovf = 0;
      m_busy = 0; m_done = 0; m_code = 0; m_anode = 4'b1110;
    end else begin
      m_e++;
      m_idx   = (m_e / 4) % 4;
      m_code  = digit_of(m_disp, m_idx, blank_lz);
      m_anode = ~(4'b0001 << m_idx);
      m_done  = 0;
      if (m_infl) begin
        if (m_e - m_acc == 15) begin
          m_disp = (m_val > 9999) ? 9999 : m_val;
          m_ovf  = (m_val > 9999);
          m_done = 1;
          m_infl = 0;
        end
      end else if (load) begin
        m_infl = 1;
        m_acc  = m_e;
        m_val  = int'(value);
      end
      m_busy = m_infl && (m_e - m_acc) <= 13;
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("model_code",  digit_code, m_code);
      chk("model_anode", anode, m_anode);
      chk("model_busy",  busy, m_busy);
      chk("model_done",  done, m_done);
      chk("model_ovf",   overflow, m_ovf);
    end
  end

  task automatic do_load(input int v);
    value = v[13:0];
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) break;
    end
    chk("done_seen", done, 1);
  endtask

  // Observe one full scan (16 cycles) and compare each digit position.
  task automatic scan_check(input logic [15:0] exp, input string tag);
    logic [15:0] got;
    int k;
    got = 16'hxxxx;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      k = -1;
      for (int j = 0; j < 4; j++) if (anode[j] === 1'b0) k = j;
      if (k >= 0) got[4*k +: 4] = digit_code;
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_d%0d", tag, i), got[4*i +: 4], exp[4*i +: 4]);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_anode"}, anode, 4'b1110);
    chk({tag, "_code"},  digit_code, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_ovf"},   overflow, 0);
  endtask

  typedef struct {
    int          val;
    bit          blz;
    logic [15:0] digs;
    bit          ovf;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int lat, busy_cnt, done_at, ndone;

    tbl[0]  = '{1234,  1'b0, 16'h1234, 1'b0};
    tbl[1]  = '{7,     1'b1, 16'hFFF7, 1'b0};
    tbl[2]  = '{7,     1'b0, 16'h0007, 1'b0};
    tbl[3]  = '{12000, 1'b0, 16'h9999, 1'b1};
    tbl[4]  = '{0,     1'b0, 16'h0000, 1'b0};
    tbl[5]  = '{0,     1'b1, 16'hFFF0, 1'b0};
    tbl[6]  = '{16383, 1'b1, 16'h9999, 1'b1};
    tbl[7]  = '{9999,  1'b0, 16'h9999, 1'b0};
    tbl[8]  = '{100,   1'b1, 16'hF100, 1'b0};
    tbl[9]  = '{1005,  1'b1, 16'h1005, 1'b0};
    tbl[10] = '{10000, 1'b0, 16'h9999, 1'b1};
    tbl[11] = '{60,    1'b1, 16'hFF60, 1'b0};

    value = '0; load = 1'b0; blank_lz = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    #2 rst_n = 1'b1;
    chk_en = 1;

    // Idle scan with an all-zero display
    repeat (20) @(negedge clk);

    // Latency of a single conversion
    value = 14'd1234; load = 1'b1;
    busy_cnt = 0; done_at = -1;
    for (lat = 1; lat <= 24; lat++) begin
      @(negedge clk);
      if (lat == 1) load = 1'b0;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_at = lat;
        break;
      end
    end
    chk("done_latency", done_at, 16);
    chk("busy_cycles", busy_cnt, 14);
    scan_check(16'h1234, "lat1234");
    chk("lat1234_ovf", overflow, 0);

    // Table of values
    for (int t = 0; t < 12; t++) begin
      blank_lz = tbl[t].blz;
      do_load(tbl[t].val);
      wait_done();
      chk($sformatf("tbl%0d_ovf", t), overflow, tbl[t].ovf);
      scan_check(tbl[t].digs, $sformatf("tbl%0d", t));
    end

    // Second load during SHIFT is dropped
    blank_lz = 1'b0;
    do_load(5678);
    repeat (3) @(negedge clk);
    do_load(1111);
    wait_done();
    scan_check(16'h5678, "busyload");
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("busyload_extra_done", ndone, 0);

    // Reset in the middle of a conversion
    do_load(4321);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    scan_check(16'h0000, "midrst");

    // Random loads and blanking changes against the model
    repeat (500) begin
      @(negedge clk);
      load = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       value = 14'($urandom_range(0, 16383));
        1:       value = 14'($urandom_range(0, 99));
        default: value = 14'($urandom_range(0, 9999));
      endcase
      if ($urandom_range(0, 7) == 0) blank_lz = ~blank_lz;
    end
    @(negedge clk);
    load = 1'b0;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
